pr_switch_counter: RTL and testbench

- Logic that lives inside one partial-reconfiguration region of the Arty switch-processing overlay. It is the far end of the overlay's in_prN/out_prN buffer pair.
- Takes the 4 switch bits the overlay drives into the region, then synchronises and debounces them.
- Runs an up/down event counter from debounced switch edges and returns a 4-bit result to the overlay, which forwards it to the next region or to the LEDs.
- One instance is placed per region; two instances chained through the overlay form the full pipeline.

---
 rtl/pr_switch_counter.sv | 113 +++++++++++
 tb/tb_pr_switch_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pr_switch_counter.sv
// pr_switch_counter
// -----------------
// Logic for one partial-reconfiguration region of the switch-processing overlay.
// It takes the four raw switch bits the overlay drives into the region. Each bit
// is synchronised and debounced. Rising edges of the debounced bits drive a
// 4-bit up/down event counter. A registered 4-bit result goes back to the
// overlay.
//
// Ports:
//   clk     in   1  region clock
//   rst     in   1  asynchronous active-low reset. Assertion clears all state
//                   at once; release is seen on the following clk edges.
//   in_pr   in   4  raw switch bits, asynchronous to clk
//                     [0] count up, [1] count down, [2] clear, [3] mode
//   out_pr  out  4  registered result
//                     mode 0: event count
//                     mode 1: {heartbeat, debounced bits [2:0]}
//
// Handshake: none. out_pr is a plain register and is valid on every cycle after
// reset release. There is no valid/ready pair.
//
// Latency: a new stable in_pr value is sampled first at edge 1. The matching
// out_pr change appears after edge SYNC_STAGES + DEBOUNCE_CYCLES + 2.

module pr_switch_counter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEBOUNCE_W      = 16,
  parameter int HB_W            = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_pr,
  output logic [3:0] out_pr
);

  localparam logic [DEBOUNCE_W-1:0] DB_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEBOUNCE_W-1:0] DB_ONE  = DEBOUNCE_W'(1);

  // Each stage of the synchroniser holds all four bits. Stage 0 samples in_pr.
  logic [SYNC_STAGES-1:0][3:0]  sync_q;
  logic [3:0]                   sync_last;

  logic [3:0]                   db_q, db_d;      // debounced bits
  logic [3:0]                   db_dly_q;        // db one cycle later, for edge detect
  logic [3:0][DEBOUNCE_W-1:0]   cnt_q, cnt_d;    // per-bit debounce counters
  logic [3:0]                   rise;
  logic [3:0]                   count_q, count_d;
  logic [HB_W-1:0]              hb_q;
  logic [3:0]                   out_q, out_d;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = db_q & ~db_dly_q;
  assign out_pr    = out_q;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      // Any return to agreement restarts the count. Only an unbroken run of
      // DEBOUNCE_CYCLES disagreeing cycles moves the debounced value.
      if (sync_last[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = sync_last[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_ONE;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    // Clear wins over everything. Simultaneous up and down cancel out.
    if (rise[2]) begin
      count_d = 4'd0;
    end else if (rise[0] && rise[1]) begin
      count_d = count_q;
    end else if (rise[0]) begin
      count_d = count_q + 4'd1;
    end else if (rise[1]) begin
      count_d = count_q - 4'd1;
    end
  end

  // The mode comes from the delayed debounced bit. The mode change and the
  // pass-through bits therefore reach out_pr on the same update.
  always_comb begin
    out_d = db_dly_q[3] ? {hb_q[HB_W-1], db_dly_q[2:0]} : count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      hb_q     <= '0;
      out_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_pr};
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      hb_q     <= hb_q + HB_W'(1);
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_pr_switch_counter.sv
// Testbench for pr_switch_counter.
// The DUT is built with SYNC_STAGES=2, DEBOUNCE_CYCLES=4 and HB_W=4.
// A reference model of the switch/counter behaviour runs inside the bench and
// is compared on every cycle. Directed tests add hand-computed literal checks.

module tb_pr_switch_counter;

  localparam int S   = 2;
  localparam int DC  = 4;
  localparam int HBW = 4;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic [3:0] in_pr;
  logic [3:0] out_pr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pr_switch_counter #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DC),
    .DEBOUNCE_W     (16),
    .HB_W           (HBW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in_pr  (in_pr),
    .out_pr (out_pr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // ---------------- reference model ----------------
  // samp_q holds the raw samples. The synchronised view is the sample taken
  // S-1 edges earlier. syn_q holds the last DC synchronised values. A
  // debounced bit moves only when all of those values disagree with it.
  logic [3:0]     samp_q[$];
  logic [3:0]     syn_q[$];
  logic [3:0]     m_db, m_dbq, m_cnt, m_out, m_rise, m_nd, m_syn;
  logic [HBW-1:0] m_hb;
  bit             all_diff;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_db  = '0;
      m_dbq = '0;
      m_cnt = '0;
      m_out = '0;
      m_hb  = '0;
      samp_q.delete();
      syn_q.delete();
      for (int k = 0; k < DC; k++) syn_q.push_back(4'h0);
    end else begin
      m_out  = m_dbq[3] ? {m_hb[HBW-1], m_dbq[2:0]} : m_cnt;
      m_rise = m_db & ~m_dbq;
      if (m_rise[2])                 m_cnt = 4'd0;
      else if (m_rise[0] && m_rise[1]) m_cnt = m_cnt;
      else if (m_rise[0])            m_cnt = 4'((int'(m_cnt) + 1) % 16);
      else if (m_rise[1])            m_cnt = 4'((int'(m_cnt) + 15) % 16);
      m_nd = m_db;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++)
          if (syn_q[syn_q.size()-1-k][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) m_nd[i] = ~m_db[i];
      end
      m_dbq = m_db;
      m_db  = m_nd;
      samp_q.push_back(in_pr);
      if (samp_q.size() > S) void'(samp_q.pop_front());
      m_syn = (samp_q.size() == S) ? samp_q[0] : 4'h0;
      syn_q.push_back(m_syn);
      if (syn_q.size() > DC) void'(syn_q.pop_front());
      m_hb = m_hb + HBW'(1);
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (out_pr !== m_out) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t out_pr=%h expected=%h", $time, out_pr, m_out);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Drives in_pr at a negedge, then waits n more negedges. That is n posedges.
  task automatic go(input logic [3:0] v, input int n);
    in_pr = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_up(input logic [3:0] exp, input string name);
    go(4'h1, 8);
    check(name, out_pr, exp);
    go(4'h0, 8);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst   = 1'b0;
    in_pr = 4'hF;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out", out_pr, 4'h0);

    // 1: release with all switches high. Clear wins, and the mode goes to 1.
    rst = 1'b1;
    repeat (7) @(negedge clk);
    check("rel_edge7", out_pr, 4'h0);
    @(negedge clk);
    check("rel_edge8", out_pr, 4'h7);   // hb count 7 -> msb 0
    @(negedge clk);
    check("rel_edge9", out_pr, 4'hF);   // hb count 8 -> msb 1
    go(4'h0, 12);
    check("rel_count0", out_pr, 4'h0);

    // 2: latency and glitch rejection
    in_pr = 4'h1;
    repeat (7) @(negedge clk);
    check("lat_edge7", out_pr, 4'h0);
    @(negedge clk);
    check("lat_edge8", out_pr, 4'h1);
    go(4'h0, 10);
    go(4'h1, 3);
    go(4'h0, 12);
    check("glitch3", out_pr, 4'h1);

    // 3: clear, then 16 ups wrap to 0, one down to 15, simultaneous up/down
    go(4'h4, 8);
    check("clr", out_pr, 4'h0);
    go(4'h0, 8);
    for (int k = 0; k < 16; k++) pulse_up(4'((k + 1) % 16), "wrap_up");
    go(4'h2, 8);
    check("down_wrap", out_pr, 4'hF);
    go(4'h0, 8);
    go(4'h3, 8);
    check("updown_same", out_pr, 4'hF);
    go(4'h0, 8);

    // 4: clear priority at count 9
    for (int k = 0; k < 10; k++) pulse_up(4'((15 + k + 1) % 16), "to_nine");
    go(4'h5, 8);
    check("clr_prio", out_pr, 4'h0);
    go(4'h0, 8);

    // 5: mode 1. The in_pr[1] rise arrives together with mode and counts down.
    for (int k = 0; k < 5; k++) pulse_up(4'(k + 1), "to_five");
    go(4'b1010, 8);
    check("mode_pass", {1'b0, out_pr[2:0]}, 4'b0010);
    repeat (24) @(negedge clk);
    go(4'b0010, 8);
    check("mode_back", out_pr, 4'h4);
    go(4'h0, 8);

    // 6: async reset mid-operation at count 7, mid-debounce of bit 1
    for (int k = 0; k < 3; k++) pulse_up(4'(k + 5), "to_seven");
    in_pr = 4'h2;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("async_rst", out_pr, 4'h0);
    in_pr = 4'h6;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst", out_pr, 4'h0);

    go(4'h0, 10);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
